mem_arbiter: RTL and testbench

//  Memory-side arbiter directly downstream of the per-CPU icache/dcache pair.

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_rr_pick.sv | 32 +++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-side arbiter: RAM handshake states, arbiter FSM
// states and the word/burst addressing constants.
package mem_arbiter_pkg;

  localparam int WORD_W       = 32;
  localparam int WORD_SEL_BIT = 2;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

  // A RAM transaction ends on ACCESS or ERROR; both release the requester.
  function automatic logic ram_finished(input ramstate_t s);
    return (s == ACCESS) || (s == ERROR);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin picker: returns the first requesting index at or after start,
// wrapping modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] start,
  output logic [PW-1:0] idx,
  output logic          valid
);

  function automatic logic [PW-1:0] slot(input int k);
    int s;
    s = int'(start) + k;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  // Scan from the farthest slot back to start so the closest requester wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[slot(k)]) begin
        valid = 1'b1;
        idx   = slot(k);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Memory-side arbiter: merges per-CPU icache and dcache request streams onto
// one RAM port, locking a dcache grant across its two-word block burst.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int CPUS    = 2,
  parameter int LAT_MAX = 15
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CPUS-1:0]      iREN,
  input  word_t [CPUS-1:0]     iaddr,
  output logic [CPUS-1:0]      iwait,
  output word_t [CPUS-1:0]     iload,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  word_t [CPUS-1:0]     daddr,
  input  word_t [CPUS-1:0]     dstore,
  output logic [CPUS-1:0]      dwait,
  output word_t [CPUS-1:0]     dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output word_t                ramaddr,
  output word_t                ramstore,
  input  word_t                ramload,
  input  ramstate_t            ramstate,
  output logic                 err,
  output arb_state_t           arb_state
);

  localparam int PTR_W = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int WD_W  = $clog2(LAT_MAX + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(LAT_MAX);

  // Cache handshake: a requester holds xREN/xWEN and its address until xwait
  // drops; the word moves in the cycle xwait is low, loads valid only then.

  arb_state_t       state;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] rr_ptr;
  logic [WD_W-1:0]  wdog;

  logic [CPUS-1:0]  dreq;
  logic [PTR_W-1:0] d_idx, i_idx;
  logic             d_valid, i_valid;
  logic             own_dreq, own_ireq, own_req;
  logic             timeout, fault, done, last_word;
  logic [PTR_W-1:0] next_rr;

  assign dreq      = dREN | dWEN;
  assign arb_state = state;

  rr_pick #(.N(CPUS), .PW(PTR_W)) u_dpick (
    .req   (dreq),
    .start (rr_ptr),
    .idx   (d_idx),
    .valid (d_valid)
  );

  rr_pick #(.N(CPUS), .PW(PTR_W)) u_ipick (
    .req   (iREN),
    .start (rr_ptr),
    .idx   (i_idx),
    .valid (i_valid)
  );

  assign own_dreq  = dreq[owner];
  assign own_ireq  = iREN[owner];
  assign own_req   = (state == DGRANT) ? own_dreq :
                     (state == IGRANT) ? own_ireq : 1'b0;
  assign timeout   = (ramstate == BUSY) && (wdog == WD_MAX);
  assign fault     = (ramstate == ERROR) || timeout;
  assign done      = own_req && (ram_finished(ramstate) || timeout);
  assign last_word = daddr[owner][WORD_SEL_BIT];
  assign next_rr   = (owner == PTR_W'(CPUS - 1)) ? '0 : owner + PTR_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      err    <= 1'b0;
      wdog   <= '0;
    end else begin
      if (done && fault) err <= 1'b1;

      // Only an unbroken run of BUSY cycles inside a live grant ages the watchdog.
      if (own_req && (ramstate == BUSY) && !done)
        wdog <= (wdog == WD_MAX) ? wdog : wdog + WD_W'(1);
      else
        wdog <= '0;

      case (state)
        IDLE: begin
          if (d_valid) begin
            state <= DGRANT;
            owner <= d_idx;
          end else if (i_valid) begin
            state <= IGRANT;
            owner <= i_idx;
          end
        end
        DGRANT: begin
          // Word0 completion keeps the lock so the burst's word1 follows directly.
          if (!own_dreq || (done && last_word)) begin
            state  <= IDLE;
            rr_ptr <= next_rr;
          end
        end
        IGRANT: begin
          if (!own_ireq || done) begin
            state  <= IDLE;
            rr_ptr <= next_rr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      DGRANT: begin
        if (own_dreq) begin
          ramWEN   = dWEN[owner];
          ramREN   = dREN[owner] & ~dWEN[owner];
          ramaddr  = daddr[owner];
          ramstore = dstore[owner];
          if (done) begin
            dwait[owner] = 1'b0;
            dload[owner] = fault ? '0 : ramload;
          end
        end
      end
      IGRANT: begin
        if (own_ireq) begin
          ramREN  = 1'b1;
          ramaddr = iaddr[owner];
          if (done) begin
            iwait[owner] = 1'b0;
            iload[owner] = fault ? '0 : ramload;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: queued cache requests per port, a small RAM
// responder with programmable latency/stuck/error, and checked completion logs.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int CPUS    = 2;
  localparam int LAT_MAX = 15;

  logic                CLK = 1'b0;
  logic                RST;
  logic [CPUS-1:0]     iREN;
  word_t [CPUS-1:0]    iaddr;
  logic [CPUS-1:0]     iwait;
  word_t [CPUS-1:0]    iload;
  logic [CPUS-1:0]     dREN;
  logic [CPUS-1:0]     dWEN;
  word_t [CPUS-1:0]    daddr;
  word_t [CPUS-1:0]    dstore;
  logic [CPUS-1:0]     dwait;
  word_t [CPUS-1:0]    dload;
  logic                ramREN;
  logic                ramWEN;
  word_t               ramaddr;
  word_t               ramstore;
  word_t               ramload;
  ramstate_t           ramstate;
  logic                err;
  arb_state_t          arb_state;

  mem_arbiter #(.CPUS(CPUS), .LAT_MAX(LAT_MAX)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .dwait     (dwait),
    .dload     (dload),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramload   (ramload),
    .ramstate  (ramstate),
    .err       (err),
    .arb_state (arb_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  typedef struct { bit ren; bit wen; word_t addr; word_t data; } op_t;
  typedef struct { bit is_i; int cpu; word_t addr; word_t data; int cyc; bit err_s; } comp_t;
  typedef struct { bit wr; word_t addr; word_t data; } ram_op_t;

  op_t         dq [CPUS][$];
  op_t         iq [CPUS][$];
  comp_t       log_q[$];
  ram_op_t     rlog[$];
  logic [31:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  int ram_lat   = 2;
  bit ram_stuck = 1'b0;
  bit ram_err   = 1'b0;
  int busy_cnt  = 0;

  // ---------------- RAM responder ----------------
  always_comb begin
    if (!(ramREN || ramWEN))          ramstate = FREE;
    else if (ram_err)                 ramstate = ERROR;
    else if (ram_stuck || busy_cnt < ram_lat) ramstate = BUSY;
    else                              ramstate = ACCESS;
    ramload = (ramstate == ACCESS && ramREN) ? (ramaddr ^ 32'hCAFE_0000) : 32'hDEAD_BEEF;
  end

  always @(posedge CLK) begin
    if ((ramREN || ramWEN) && ramstate == ACCESS) begin
      ram_op_t r;
      r.wr   = ramWEN;
      r.addr = ramaddr;
      r.data = ramstore;
      rlog.push_back(r);
    end
    if (RST || ramstate != BUSY) busy_cnt <= 0;
    else                         busy_cnt <= busy_cnt + 1;
  end

  // ---------------- expected tables ----------------
  word_t t3_addr [3] = '{32'h100, 32'h104, 32'h400};
  word_t t3_data [3] = '{32'hCAFE_0100, 32'hCAFE_0104, 32'hCAFE_0400};
  int    t3_is_i [3] = '{0, 0, 1};
  int    t3_cpu  [3] = '{0, 0, 1};
  int    t3_cyc  [3] = '{3, 6, 10};
  word_t t4_addr [12] = '{32'h1000, 32'h1004, 32'h2000, 32'h2004,
                          32'h1010, 32'h1014, 32'h2010, 32'h2014,
                          32'h1020, 32'h1024, 32'h2020, 32'h2024};
  int    t4_cpu  [12] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
  int    t5_wr   [4]  = '{1, 1, 0, 0};
  word_t t5_addr [4]  = '{32'h200, 32'h204, 32'h300, 32'h304};

  // ---------------- driver tasks ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_d(input int c, input bit ren, input bit wen, input word_t a, input word_t d);
    op_t o;
    o.ren = ren; o.wen = wen; o.addr = a; o.data = d;
    dq[c].push_back(o);
  endtask

  task automatic push_i(input int c, input word_t a);
    op_t o;
    o.ren = 1'b1; o.wen = 1'b0; o.addr = a; o.data = '0;
    iq[c].push_back(o);
  endtask

  function automatic int pending();
    int n = 0;
    for (int c = 0; c < CPUS; c++) n += dq[c].size() + iq[c].size();
    return n;
  endfunction

  task automatic present();
    for (int c = 0; c < CPUS; c++) begin
      if (dq[c].size() > 0) begin
        dREN[c]   = dq[c][0].ren;
        dWEN[c]   = dq[c][0].wen;
        daddr[c]  = dq[c][0].addr;
        dstore[c] = dq[c][0].data;
      end else begin
        dREN[c] = 1'b0;
        dWEN[c] = 1'b0;
      end
      if (iq[c].size() > 0) begin
        iREN[c]  = 1'b1;
        iaddr[c] = iq[c][0].addr;
      end else begin
        iREN[c] = 1'b0;
      end
    end
  endtask

  // Present queued requests, log each completion with its cycle index.
  task automatic run(input int budget);
    int    cyc;
    comp_t e;
    cyc = 0;
    present();
    while (pending() > 0 && cyc < budget) begin
      @(negedge CLK);
      for (int c = 0; c < CPUS; c++) begin
        if (dq[c].size() > 0 && !dwait[c]) begin
          e.is_i = 1'b0; e.cpu = c; e.addr = dq[c][0].addr;
          e.data = dload[c]; e.cyc = cyc; e.err_s = err;
          log_q.push_back(e);
          void'(dq[c].pop_front());
        end
        if (iq[c].size() > 0 && !iwait[c]) begin
          e.is_i = 1'b1; e.cpu = c; e.addr = iq[c][0].addr;
          e.data = iload[c]; e.cyc = cyc; e.err_s = err;
          log_q.push_back(e);
          void'(iq[c].pop_front());
        end
      end
      @(posedge CLK); #1;
      cyc++;
      present();
    end
    chk("run_drained", pending(), 0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    dREN = '0; dWEN = '0; iREN = '0;
    daddr = '0; dstore = '0; iaddr = '0;
    ram_stuck = 1'b0; ram_err = 1'b0;
    for (int c = 0; c < CPUS; c++) begin
      dq[c].delete();
      iq[c].delete();
    end
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    log_q.delete();
    rlog.delete();
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed=still running expected=finished");
    $fatal(1, "bench timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;

    // Reset state
    do_reset();
    @(negedge CLK);
    chk("rst_state",  arb_state, IDLE);
    chk("rst_iwait",  iwait, 2'b11);
    chk("rst_dwait",  dwait, 2'b11);
    chk("rst_ramREN", ramREN, 1'b0);
    chk("rst_ramWEN", ramWEN, 1'b0);
    chk("rst_err",    err, 1'b0);
    chk("rst_iload",  iload, 64'h0);
    chk("rst_dload",  dload, 64'h0);
    @(posedge CLK); #1;

    // Single dREN burst on cpu0, two BUSY cycles per word
    do_reset();
    push_d(0, 1, 0, 32'h100, 0);
    push_d(0, 1, 0, 32'h104, 0);
    exp_q.push_back(32'hCAFE_0100);
    exp_q.push_back(32'hCAFE_0104);
    run(40);
    chk("burst_count", log_q.size(), 2);
    for (int i = 0; i < log_q.size() && i < 2; i++) begin
      chk("burst_data", log_q[i].data, exp_q.pop_front());
      chk("burst_cyc",  log_q[i].cyc, t3_cyc[i]);
      chk("burst_cpu",  log_q[i].cpu, 0);
    end

    // Data burst on cpu0 beats a same-cycle icache request on cpu1
    do_reset();
    push_d(0, 1, 0, 32'h100, 0);
    push_d(0, 1, 0, 32'h104, 0);
    push_i(1, 32'h400);
    run(60);
    chk("mix_count", log_q.size(), 3);
    for (int i = 0; i < log_q.size() && i < 3; i++) begin
      chk("mix_is_i", log_q[i].is_i, t3_is_i[i]);
      chk("mix_cpu",  log_q[i].cpu,  t3_cpu[i]);
      chk("mix_addr", log_q[i].addr, t3_addr[i]);
      chk("mix_data", log_q[i].data, t3_data[i]);
      chk("mix_cyc",  log_q[i].cyc,  t3_cyc[i]);
    end

    // Two writers contending: grants alternate per two-word burst
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push_d(0, 0, 1, 32'h1000 + 32'(16 * k), 32'h1001 + 32'(16 * k));
      push_d(0, 0, 1, 32'h1004 + 32'(16 * k), 32'h1005 + 32'(16 * k));
      push_d(1, 0, 1, 32'h2000 + 32'(16 * k), 32'h2001 + 32'(16 * k));
      push_d(1, 0, 1, 32'h2004 + 32'(16 * k), 32'h2005 + 32'(16 * k));
    end
    run(300);
    chk("alt_count", rlog.size(), 12);
    for (int i = 0; i < rlog.size() && i < 12; i++) begin
      chk("alt_addr", rlog[i].addr, t4_addr[i]);
      chk("alt_data", rlog[i].data, t4_addr[i] + 32'h1);
      chk("alt_wr",   rlog[i].wr, 1'b1);
    end
    for (int i = 0; i < log_q.size() && i < 12; i++)
      chk("alt_cpu", log_q[i].cpu, t4_cpu[i]);

    // Evict then fill on cpu0; first word raises dREN and dWEN together
    do_reset();
    push_d(0, 1, 1, 32'h200, 32'h1111_0000);
    push_d(0, 0, 1, 32'h204, 32'h2222_0000);
    push_d(0, 1, 0, 32'h300, 0);
    push_d(0, 1, 0, 32'h304, 0);
    run(80);
    chk("ev_count", rlog.size(), 4);
    for (int i = 0; i < rlog.size() && i < 4; i++) begin
      chk("ev_wr",   rlog[i].wr, t5_wr[i]);
      chk("ev_addr", rlog[i].addr, t5_addr[i]);
    end
    if (rlog.size() >= 2) begin
      chk("ev_wdata0", rlog[0].data, 32'h1111_0000);
      chk("ev_wdata1", rlog[1].data, 32'h2222_0000);
    end
    if (log_q.size() >= 4) begin
      chk("fill_data0", log_q[2].data, 32'hCAFE_0300);
      chk("fill_data1", log_q[3].data, 32'hCAFE_0304);
    end

    // RAM stuck BUSY: watchdog releases on the sixteenth BUSY cycle
    do_reset();
    ram_stuck = 1'b1;
    push_d(0, 1, 0, 32'h104, 0);
    run(40);
    chk("wd_count", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      chk("wd_cyc",   log_q[0].cyc, 16);
      chk("wd_data",  log_q[0].data, 32'h0);
      chk("wd_err_pre", log_q[0].err_s, 1'b0);
    end
    @(negedge CLK);
    chk("wd_err",   err, 1'b1);
    chk("wd_state", arb_state, IDLE);
    chk("wd_dwait", dwait, 2'b11);
    ram_stuck = 1'b0;
    @(posedge CLK); #1;

    // RAM ERROR on an instruction fetch: release with zero load, sticky err
    do_reset();
    ram_err = 1'b1;
    push_i(1, 32'h500);
    run(20);
    chk("re_count", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      chk("re_is_i", log_q[0].is_i, 1'b1);
      chk("re_cpu",  log_q[0].cpu, 1);
      chk("re_cyc",  log_q[0].cyc, 1);
      chk("re_data", log_q[0].data, 32'h0);
    end
    ram_err = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("re_err_sticky", err, 1'b1);
    @(posedge CLK); #1;

    // Reset asserted after word0 of a burst aborts the grant
    do_reset();
    dREN[0]  = 1'b1;
    daddr[0] = 32'h100;
    n = 0;
    @(negedge CLK);
    while (dwait[0] && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("ra_word0_done", dwait[0], 1'b0);
    @(posedge CLK); #1;
    daddr[0] = 32'h104;
    RST = 1'b1;
    @(negedge CLK);
    chk("ra_pre_state",  arb_state, DGRANT);
    chk("ra_pre_ramREN", ramREN, 1'b1);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("ra_ramREN", ramREN, 1'b0);
    chk("ra_dwait",  dwait, 2'b11);
    chk("ra_state",  arb_state, IDLE);
    dREN[0] = 1'b0;
    @(posedge CLK); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
